// File: rtl/accel_pkg.sv
// Shared definitions for the accelerator tile control path: FSM state codes and
// the activate-read to output-write latency through the PE array.
package accel_pkg;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'd0,
    ST_WLOAD  = 6'd1,
    ST_STREAM = 6'd2,
    ST_FLUSH  = 6'd3,
    ST_DONE   = 6'd4
  } tile_state_t;

  // A vector entering the array needs ROWS cycles to cross the weights and
  // COLS more to drain out of the last column.
  function automatic int calc_lat(input int rows, input int cols);
    return rows + cols;
  endfunction

endpackage

// File: rtl/latency_pipe.sv
// Fixed delay line of DEPTH register stages, W bits wide.
// Latency DEPTH enabled cycles; no backpressure, en=0 holds every stage.
module latency_pipe #(
  parameter int DEPTH = 32,
  parameter int W     = 11
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  logic [W-1:0] stage [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else if (en) begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/tile_sequencer.sv
// Sequences one PE-array tile: weight preload, activation stream, output drain.
// Output write trails its activate read by ROWS+COLS cycles; EN=0 freezes everything.
module tile_sequencer
  import accel_pkg::*;
#(
  parameter int ROWS = 16,
  parameter int COLS = 16,
  parameter int AW   = 13,
  parameter int KW   = 10
) (
  input  logic          CLK,
  input  logic          RESET,
  input  logic          EN,
  input  logic          START,
  input  logic [AW-1:0] IADDR,
  input  logic [AW-1:0] WADDR,
  input  logic [AW-1:0] OADDR,
  input  logic [KW-1:0] K_LEN,
  output logic [5:0]    STATE,
  output logic          BUSY,
  output logic          DONE,
  output logic          W_EN,
  output logic          SELECTOR,
  output logic          weight_cen,
  output logic          weight_wen,
  output logic          activate_cen,
  output logic          activate_wen,
  output logic          output_cen,
  output logic          output_wen,
  output logic [AW-1:0] weight_addr,
  output logic [AW-1:0] activate_addr,
  output logic [AW-1:0] output_addr
);

  localparam int LAT  = calc_lat(ROWS, COLS);
  localparam int LATW = $clog2(LAT + 1);
  localparam int CW   = (KW > LATW) ? KW : LATW;

  tile_state_t   state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] iaddr_q, waddr_q, oaddr_q;
  logic [KW-1:0] k_q;
  logic          w_pend;
  logic          w_rd, a_rd, o_wr;
  logic [KW:0]   pipe_out;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state   <= ST_IDLE;
      cnt     <= '0;
      w_pend  <= 1'b0;
      iaddr_q <= '0;
      waddr_q <= '0;
      oaddr_q <= '0;
      k_q     <= '0;
    end else if (EN) begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      // Weight SRAM has one cycle of read latency; latch strobe follows the read.
      w_pend <= (state == ST_WLOAD);
      if (state == ST_IDLE && START) begin
        iaddr_q <= IADDR;
        waddr_q <= WADDR;
        oaddr_q <= OADDR;
        k_q     <= K_LEN;
      end
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (START) begin
          state_nxt = ST_WLOAD;
          cnt_nxt   = '0;
        end
      end
      ST_WLOAD: begin
        if (cnt == CW'(ROWS - 1)) begin
          cnt_nxt   = '0;
          state_nxt = (k_q == '0) ? ST_DONE : ST_STREAM;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_STREAM: begin
        if ((cnt + CW'(1)) == CW'(k_q)) begin
          cnt_nxt   = '0;
          state_nxt = ST_FLUSH;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_FLUSH: begin
        if (cnt == CW'(LAT - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_DONE;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Carries {valid, stream index} from each activate read to its output write.
  latency_pipe #(
    .DEPTH (LAT),
    .W     (KW + 1)
  ) u_out_pipe (
    .clk   (CLK),
    .rst_n (RESET),
    .en    (EN),
    .din   ({a_rd, cnt[KW-1:0]}),
    .dout  (pipe_out)
  );

  assign w_rd = EN && (state == ST_WLOAD);
  assign a_rd = EN && (state == ST_STREAM);
  assign o_wr = EN && pipe_out[KW];

  assign weight_cen    = !w_rd;
  assign weight_wen    = 1'b1;
  assign weight_addr   = w_rd ? (waddr_q + AW'(cnt)) : '0;
  assign activate_cen  = !a_rd;
  assign activate_wen  = 1'b1;
  assign activate_addr = a_rd ? (iaddr_q + AW'(cnt)) : '0;
  assign output_cen    = !o_wr;
  assign output_wen    = !o_wr;
  assign output_addr   = o_wr ? (oaddr_q + AW'(pipe_out[KW-1:0])) : '0;

  assign STATE    = state;
  assign BUSY     = (state != ST_IDLE);
  // Gated so a frozen DONE state still yields a single pulse.
  assign DONE     = EN && (state == ST_DONE);
  assign W_EN     = EN && w_pend;
  assign SELECTOR = (state == ST_STREAM) || (state == ST_FLUSH) || (state == ST_DONE);

endmodule

// File: doc/tile_sequencer.md
TILE_SEQUENCER -- requirements
Module: tile_sequencer

Interface
REQ-001 SHALL have parameter ROWS, default 16, meaning PE array rows (weight vectors preloaded per tile).
REQ-002 SHALL have parameter COLS, default 16, meaning PE array columns (output lanes).
REQ-003 SHALL have parameter AW, default 13, meaning SRAM address width.
REQ-004 SHALL have parameter KW, default 10, meaning K_LEN counter width.
REQ-005 SHALL have port CLK  input  1  clock; single clock domain; reset is synchronous and active-low.
REQ-006 SHALL have port RESET  input  1  synchronous active-low reset, sampled on CLK rising edge.
REQ-007 SHALL have port EN  input  1  global enable; low freezes all state.
REQ-008 SHALL have port START  input  1  tile start request, sampled only in IDLE.
REQ-009 SHALL have ports IADDR/WADDR/OADDR  input  AW each  input, weight and output base addresses.
REQ-010 SHALL have port K_LEN  input  KW  number of input vectors streamed per tile.
REQ-011 SHALL have port STATE  output  6  current FSM state code.
REQ-012 SHALL have ports BUSY, DONE  output  1 each  busy flag and one-cycle completion pulse.
REQ-013 SHALL have ports W_EN, SELECTOR  output  1 each  PE weight-latch strobe and mode (0 load, 1 compute).
REQ-014 SHALL have ports {weight,activate,output}_{cen,wen}  output  1 each  active-low SRAM chip/write enables.
REQ-015 SHALL have ports {weight,activate,output}_addr  output  AW each  SRAM addresses.

Function
REQ-016 SHALL implement states IDLE=0, WLOAD=1, STREAM=2, FLUSH=3, DONE=4.
REQ-017 IDLE SHALL move to WLOAD on the edge where START=1 and EN=1, latching IADDR/WADDR/OADDR/K_LEN.
REQ-018 WLOAD SHALL last exactly ROWS cycles, issuing weight reads (cen=0, wen=1) at WADDR+i, i=0..ROWS-1.
REQ-019 W_EN SHALL be high for exactly ROWS cycles, delayed one cycle from each weight read (SRAM read latency 1).
REQ-020 STREAM SHALL last K_LEN cycles, issuing activate reads at IADDR+k, k=0..K_LEN-1; SELECTOR=1 from first STREAM cycle until DONE exits.
REQ-021 Each activate read issued at cycle t SHALL produce an output write (output_cen=0, output_wen=0) at cycle t+LAT, LAT=ROWS+COLS, address OADDR+k, tracked by an LAT-deep valid/index shift pipeline.
REQ-022 FLUSH SHALL last LAT cycles after the final STREAM cycle, then enter DONE.
REQ-023 DONE SHALL last one cycle with DONE=1 and return to IDLE; BUSY=1 in every state except IDLE.
REQ-024 K_LEN=0 SHALL go WLOAD→DONE directly, with zero activate reads and zero output writes.
REQ-025 Address arithmetic SHALL be modulo 2^AW (base+offset wraps to 0).
REQ-026 START while BUSY SHALL be ignored; START in the DONE cycle SHALL be ignored.
REQ-027 EN=0 SHALL hold FSM, counters and pipeline, and force all cen=1, wen=1, W_EN=0 that cycle; resume exactly where frozen.
REQ-028 Base/K_LEN input changes after START is accepted SHALL not affect the running tile.
REQ-029 All cen/wen SHALL be 1 whenever no access is issued.

Reset
REQ-030 RESET=0 at a rising edge SHALL force IDLE, clear counters and pipeline, and set STATE=0, BUSY=0, DONE=0, W_EN=0, SELECTOR=0, all cen/wen=1 and all addr=0, including mid-tile.
REQ-031 No write SHALL issue in the cycle following a reset edge.

Structure
REQ-032 State codes and LAT derivation SHALL be placed in shared package accel_pkg.
REQ-033 The output valid/index delay line SHALL be sub-module latency_pipe (params DEPTH, W).

Verification
REQ-034 16x16, WADDR=0x100, IADDR=0x200, OADDR=0x300, K_LEN=8, START → 16 weight reads 0x100-0x10F; reads 0x200-0x207; writes 0x300-0x307 32 cycles after each; DONE 57 cycles after START accepted.
REQ-035 K_LEN=0 → 16 weight reads, DONE in cycle 17 after acceptance, no activate/output access.
REQ-036 OADDR=0x1FFE, K_LEN=4 → writes 0x1FFE, 0x1FFF, 0x0000, 0x0001.
REQ-037 EN low 3 cycles mid-STREAM → no accesses during the gap; address sequence continues unbroken; DONE delayed exactly 3 cycles.
REQ-038 RESET low during FLUSH → next cycle STATE=0, all enables inactive; a new START then runs a full clean tile.
REQ-039 START pulsed during STREAM and in DONE cycle → ignored; exactly one tile completes.
